// File: rtl/load_ext_unit.sv
// load_ext_unit
// Load-data extender for the MIPS memory stage. Picks the addressed byte or
// halfword lane out of a little-endian memory word, sign- or zero-extends it
// to DATA_WIDTH, and passes the result through a PIPE_DEPTH-deep register
// chain with a valid/ready handshake, stall and flush.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   flush           synchronous flush, clears every stage valid bit
//   in_valid/ready  input handshake
//   in_data         raw memory word
//   in_off          byte offset of the access inside the word
//   in_mode         000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, others illegal
//   out_valid/ready output handshake
//   out_data        extended result (reads 0 whenever out_valid is 0)
//   out_err         misaligned access or illegal mode for this beat
//
// Handshake: a beat moves across a boundary on a cycle where valid && ready
// are both high there. valid never depends on ready. Stage k is ready when it
// is empty or when the stage after it is ready (ready_PIPE_DEPTH = out_ready),
// so in_ready is a combinational function of out_ready and bubbles compress.
module load_ext_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int PIPE_DEPTH = 1,
  localparam int OFF_W = $clog2(DATA_WIDTH / 8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [OFF_W-1:0]      in_off,
  input  logic [2:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err
);

  localparam logic [2:0] MODE_LB  = 3'b000;
  localparam logic [2:0] MODE_LH  = 3'b001;
  localparam logic [2:0] MODE_LW  = 3'b010;
  localparam logic [2:0] MODE_LBU = 3'b100;
  localparam logic [2:0] MODE_LHU = 3'b101;

  // ---------------------------------------------------------------
  // Input-side lane select and extension
  // ---------------------------------------------------------------
  logic [OFF_W+2:0]      byte_base;
  logic [OFF_W+2:0]      half_base;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] ext_data;
  logic                  ext_err;

  always_comb begin
    // Bit position of the byte lane; clearing bit 3 rounds down to the
    // enclosing halfword lane (works for every legal OFF_W, including 1).
    byte_base    = {in_off, 3'b000};
    half_base    = byte_base;
    half_base[3] = 1'b0;
    byte_sel     = in_data[byte_base +: 8];
    half_sel     = in_data[half_base +: 16];
    ext_data     = '0;
    ext_err      = 1'b0;
    case (in_mode)
      MODE_LB:  ext_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      MODE_LBU: ext_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      MODE_LH: begin
        if (in_off[0]) ext_err = 1'b1;
        else ext_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      end
      MODE_LHU: begin
        if (in_off[0]) ext_err = 1'b1;
        else ext_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      end
      MODE_LW: begin
        if (in_off != '0) ext_err = 1'b1;
        else ext_data = in_data;
      end
      default: ext_err = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------
  // Register chain
  // ---------------------------------------------------------------
  logic [PIPE_DEPTH-1:0] st_valid;
  logic [PIPE_DEPTH-1:0] st_err;
  logic [DATA_WIDTH-1:0] st_data [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] rdy;

  // Ready ripples back from out_ready through every stage.
  always_comb begin
    logic chain;
    chain = out_ready;
    rdy   = '0;
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      chain  = !st_valid[k] || chain;
      rdy[k] = chain;
    end
  end

  assign in_ready = rdy[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_valid <= '0;
      st_err   <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) st_data[k] <= '0;
    end else if (flush) begin
      // Data registers keep stale contents; the output is gated on valid.
      st_valid <= '0;
    end else begin
      if (rdy[0]) begin
        st_valid[0] <= in_valid;
        // Only capture payload for real beats so idle-cycle garbage on the
        // input never reaches a register.
        if (in_valid) begin
          st_data[0] <= ext_data;
          st_err[0]  <= ext_err;
        end
      end
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        if (rdy[k]) begin
          st_valid[k] <= st_valid[k-1];
          if (st_valid[k-1]) begin
            st_data[k] <= st_data[k-1];
            st_err[k]  <= st_err[k-1];
          end
        end
      end
    end
  end

  assign out_valid = st_valid[PIPE_DEPTH-1];
  assign out_data  = out_valid ? st_data[PIPE_DEPTH-1] : '0;
  assign out_err   = out_valid & st_err[PIPE_DEPTH-1];

endmodule

// File: tb/tb_load_ext_unit.sv
module tb_load_ext_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus; each instance has its own in_valid so idle ones ignore it.
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_data = '0;
  logic [2:0]  in_off = '0;
  logic [2:0]  in_mode = '0;
  logic [3:0]  iv = '0;
  logic [3:0]  ir, ov, oe;
  logic [31:0] d1, d2, d3;
  logic [63:0] d4;
  logic [63:0] od [4];
  int wid [4] = '{32, 32, 32, 64};

  int total = 0;
  int bad = 0;

  assign od[0] = {32'b0, d1};
  assign od[1] = {32'b0, d2};
  assign od[2] = {32'b0, d3};
  assign od[3] = d4;

  load_ext_unit #(.DATA_WIDTH(32), .PIPE_DEPTH(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(in_data[31:0]), .in_off(in_off[1:0]), .in_mode(in_mode),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(d1), .out_err(oe[0]));
  load_ext_unit #(.DATA_WIDTH(32), .PIPE_DEPTH(2)) u2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(in_data[31:0]), .in_off(in_off[1:0]), .in_mode(in_mode),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(d2), .out_err(oe[1]));
  load_ext_unit #(.DATA_WIDTH(32), .PIPE_DEPTH(3)) u3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(in_data[31:0]), .in_off(in_off[1:0]), .in_mode(in_mode),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(d3), .out_err(oe[2]));
  load_ext_unit #(.DATA_WIDTH(64), .PIPE_DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv[3]), .in_ready(ir[3]),
    .in_data(in_data), .in_off(in_off), .in_mode(in_mode),
    .out_valid(ov[3]), .out_ready(out_ready), .out_data(d4), .out_err(oe[3]));

  // ---------------- reference model ----------------
  // Returns {err, data}. Extension done with plain integer arithmetic.
  function automatic logic [64:0] ref_ext(int w, logic [63:0] raw, int off_in, logic [2:0] mode);
    logic [63:0] wmask, data, b, h, r;
    logic err;
    int off;
    wmask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    data = raw & wmask;
    off = off_in % (w / 8);
    b = (data >> (8 * off)) & 64'hFF;
    h = (data >> (16 * (off / 2))) & 64'hFFFF;
    err = 1'b0;
    r = '0;
    case (mode)
      3'd0: r = (b >= 128) ? b - 64'd256 : b;
      3'd4: r = b;
      3'd1, 3'd5: begin
        if (off % 2 != 0) err = 1'b1;
        else r = (mode == 3'd1 && h >= 32768) ? h - 64'd65536 : h;
      end
      3'd2: begin
        if (off != 0) err = 1'b1;
        else r = data;
      end
      default: err = 1'b1;
    endcase
    if (err) r = '0;
    return {err, r & wmask};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset;
    #2 rst = 1'b1;
    #2;
    for (int i = 0; i < 4; i++) begin
      total++; if (ov[i] !== 1'b0) begin bad++; $display("FAIL reset_valid u%0d: got %b want 0", i, ov[i]); end
      total++; if (od[i] !== 64'd0) begin bad++; $display("FAIL reset_data u%0d: got %h want 0", i, od[i]); end
      total++; if (oe[i] !== 1'b0) begin bad++; $display("FAIL reset_err u%0d: got %b want 0", i, oe[i]); end
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      total++; if (ov[i] !== 1'b0) begin bad++; $display("FAIL post_reset_valid u%0d: got %b want 0", i, ov[i]); end
    end
  endtask

  task automatic test_ext;
    logic [2:0]  modes [7] = '{3'd0, 3'd0, 3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [2:0]  offs  [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd2, 3'd0};
    logic [31:0] exps  [7] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'h00000080,
                               32'hFFFF80FF, 32'h000080FF, 32'h80FF7F01};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      total++; if (ov[0] !== 1'b0) begin bad++; $display("FAIL ext_idle %0d: got %b want 0", i, ov[0]); end
      in_data = 64'h80FF7F01; in_mode = modes[i]; in_off = offs[i]; iv[0] = 1'b1;
      #1;
      total++; if (ir[0] !== 1'b1) begin bad++; $display("FAIL ext_ready %0d: got %b want 1", i, ir[0]); end
      @(negedge clk);
      iv[0] = 1'b0;
      total++; if (ov[0] !== 1'b1) begin bad++; $display("FAIL ext_valid %0d: got %b want 1", i, ov[0]); end
      total++; if (od[0] !== {32'b0, exps[i]}) begin bad++; $display("FAIL ext_data %0d: got %h want %h", i, od[0], exps[i]); end
      total++; if (oe[0] !== 1'b0) begin bad++; $display("FAIL ext_err %0d: got %b want 0", i, oe[0]); end
    end
  endtask

  task automatic test_errors;
    logic [2:0] modes [5] = '{3'd1, 3'd5, 3'd2, 3'd3, 3'd7};
    logic [2:0] offs  [5] = '{3'd1, 3'd3, 3'd2, 3'd0, 3'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_data = 64'h80FF7F01; in_mode = modes[i]; in_off = offs[i]; iv[0] = 1'b1;
      @(negedge clk);
      iv[0] = 1'b0;
      total++; if (ov[0] !== 1'b1) begin bad++; $display("FAIL err_valid %0d: got %b want 1", i, ov[0]); end
      total++; if (oe[0] !== 1'b1) begin bad++; $display("FAIL err_flag %0d: got %b want 1", i, oe[0]); end
      total++; if (od[0] !== 64'd0) begin bad++; $display("FAIL err_data %0d: got %h want 0", i, od[0]); end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [31:0] beats [5];
    int sent = 0;
    int recv = 0;
    for (int i = 0; i < 5; i++) beats[i] = $urandom;
    in_mode = 3'd2; in_off = 3'd0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 8);
      iv[1] = (sent < 5);
      in_data = (sent < 5) ? {32'b0, beats[sent]} : 64'd0;
      #1;
      if (cyc >= 3 && cyc < 8) begin
        total++; if (ov[1] !== 1'b1 || od[1] !== {32'b0, beats[0]}) begin bad++; $display("FAIL bp_hold cyc%0d: got v=%b %h want v=1 %h", cyc, ov[1], od[1], beats[0]); end
      end
      if (cyc == 6) begin
        total++; if (sent !== 2) begin bad++; $display("FAIL bp_accepted: got %0d want 2", sent); end
        total++; if (ir[1] !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", ir[1]); end
      end
      if (ov[1] && out_ready) begin
        total++;
        if (recv >= 5) begin bad++; $display("FAIL bp_extra: got %h want nothing", od[1]); end
        else if (od[1] !== {32'b0, beats[recv]} || oe[1] !== 1'b0) begin bad++; $display("FAIL bp_order %0d: got %h want %h", recv, od[1], beats[recv]); end
        recv++;
      end
      if (iv[1] && ir[1]) sent++;
    end
    iv[1] = 1'b0;
    total++; if (recv !== 5) begin bad++; $display("FAIL bp_count: got %0d want 5", recv); end
  endtask

  task automatic test_flush;
    int sent = 0;
    bit seen = 1'b0;
    out_ready = 1'b0; in_mode = 3'd2; in_off = 3'd0;
    for (int cyc = 0; cyc < 10 && sent < 3; cyc++) begin
      @(negedge clk);
      iv[2] = 1'b1; in_data = 64'h1000 + 64'(sent);
      #1;
      if (iv[2] && ir[2]) sent++;
    end
    @(negedge clk);
    total++; if (sent !== 3 || ir[2] !== 1'b0 || ov[2] !== 1'b1) begin bad++; $display("FAIL flush_fill: got sent=%0d rdy=%b v=%b want 3 0 1", sent, ir[2], ov[2]); end
    iv[2] = 1'b1; in_data = 64'hDEADBEEF; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; iv[2] = 1'b0;
    total++; if (ov[2] !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", ov[2]); end
    total++; if (od[2] !== 64'd0) begin bad++; $display("FAIL flush_data: got %h want 0", od[2]); end
    total++; if (oe[2] !== 1'b0) begin bad++; $display("FAIL flush_err: got %b want 0", oe[2]); end
    total++; if (ir[2] !== 1'b1) begin bad++; $display("FAIL flush_ready: got %b want 1", ir[2]); end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (ov[2]) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_dropped: got emission=%b want 0", seen); end
  endtask

  task automatic test_reset_mid;
    int sent = 0;
    bit seen = 1'b0;
    out_ready = 1'b0; in_mode = 3'd2; in_off = 3'd0;
    for (int cyc = 0; cyc < 10 && sent < 2; cyc++) begin
      @(negedge clk);
      iv[1] = 1'b1; in_data = 64'hCAFE0000 + 64'(sent);
      #1;
      if (iv[1] && ir[1]) sent++;
    end
    @(negedge clk);
    iv[1] = 1'b0;
    total++; if (ov[1] !== 1'b1) begin bad++; $display("FAIL rmid_inflight: got %b want 1", ov[1]); end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++; if (ov[1] !== 1'b0 || od[1] !== 64'd0 || oe[1] !== 1'b0) begin bad++; $display("FAIL rmid_clear: got v=%b d=%h e=%b want 0 0 0", ov[1], od[1], oe[1]); end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (ov[1]) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rmid_ghost: got emission=%b want 0", seen); end
    in_data = 64'h85; in_mode = 3'd0; in_off = 3'd0; iv[1] = 1'b1;
    @(negedge clk);
    iv[1] = 1'b0;
    total++; if (ov[1] !== 1'b0) begin bad++; $display("FAIL rmid_early: got %b want 0", ov[1]); end
    @(negedge clk);
    total++; if (ov[1] !== 1'b1 || od[1] !== 64'hFFFFFF85) begin bad++; $display("FAIL rmid_new: got v=%b %h want 1 ffffff85", ov[1], od[1]); end
    @(negedge clk);
  endtask

  task automatic test_wide;
    logic [2:0]  modes [2] = '{3'd0, 3'd5};
    logic [2:0]  offs  [2] = '{3'd7, 3'd6};
    logic [63:0] exps  [2] = '{64'hFFFFFFFFFFFFFF80, 64'h0000000000008000};
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_data = 64'h8000_0000_0000_0000; in_mode = modes[i]; in_off = offs[i]; iv[3] = 1'b1;
      @(negedge clk);
      iv[3] = 1'b0;
      n = 1;
      while (!ov[3] && n < 10) begin
        @(negedge clk);
        n++;
      end
      total++; if (n !== 4) begin bad++; $display("FAIL wide_latency %0d: got %0d want 4", i, n); end
      total++; if (od[3] !== exps[i] || oe[3] !== 1'b0) begin bad++; $display("FAIL wide_data %0d: got %h want %h", i, od[3], exps[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_random(input int idx, input int cycles);
    logic [64:0] exp_q [$];
    logic [64:0] e;
    for (int cyc = 0; cyc < cycles + 30; cyc++) begin
      @(negedge clk);
      iv[idx] = (cyc < cycles) && ($urandom_range(0, 3) != 0);
      in_data = {$urandom, $urandom};
      in_off = 3'($urandom_range(0, 7));
      in_mode = 3'($urandom_range(0, 7));
      out_ready = (cyc >= cycles) || ($urandom_range(0, 3) != 0);
      #1;
      if (!ov[idx]) begin
        total++; if (od[idx] !== 64'd0 || oe[idx] !== 1'b0) begin bad++; $display("FAIL rnd_gate u%0d: got %h want 0", idx, od[idx]); end
      end
      if (ov[idx] && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL rnd_extra u%0d: got %h want nothing", idx, od[idx]); end
        else begin
          e = exp_q.pop_front();
          if ({oe[idx], od[idx]} !== e) begin bad++; $display("FAIL rnd_data u%0d: got e=%b %h want e=%b %h", idx, oe[idx], od[idx], e[64], e[63:0]); end
        end
      end
      if (iv[idx] && ir[idx]) exp_q.push_back(ref_ext(wid[idx], in_data, int'(in_off), in_mode));
    end
    iv[idx] = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_drain u%0d: got %0d left want 0", idx, exp_q.size()); end
  endtask

  initial begin
    test_reset;
    test_ext;
    test_errors;
    test_backpressure;
    test_flush;
    test_reset_mid;
    test_wide;
    test_random(1, 300);
    test_random(3, 300);
    test_random(0, 200);
    test_random(2, 200);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
